// File: rtl/vga_capture.sv
// VGA frame grabber: recovers pixel timing from hsync/vsync, locks after one clean frame,
// streams active pixels with coordinates and produces a per-frame 16-bit checksum.
`timescale 1ns/1ps
module vga_capture #(
    parameter int H_TOTAL     = 800,
    parameter int H_ACT_START = 144,
    parameter int H_ACT       = 640,
    parameter int V_TOTAL     = 525,
    parameter int V_ACT_START = 35,
    parameter int V_ACT       = 480
) (
    input  logic        clk_100m,
    input  logic        rst,
    input  logic        vga_hsync,
    input  logic        vga_vsync,
    input  logic [2:0]  vga_r,
    input  logic [2:0]  vga_g,
    input  logic [1:0]  vga_b,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [7:0]  pix_rgb,
    output logic        frame_done,
    output logic [15:0] frame_sum,
    output logic        locked,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

    localparam logic [10:0] H_TOTAL_L = 11'(H_TOTAL);
    localparam logic [10:0] V_TOTAL_L = 11'(V_TOTAL);
    localparam logic [9:0]  H_LO      = 10'(H_ACT_START);
    localparam logic [9:0]  H_HI      = 10'(H_ACT_START + H_ACT);
    localparam logic [9:0]  V_LO      = 10'(V_ACT_START);
    localparam logic [9:0]  V_HI      = 10'(V_ACT_START + V_ACT);

    state_t      state, state_nx;
    logic        hs_q, vs_q, hs_prev, vs_prev;
    logic [7:0]  rgb_q;
    logic [1:0]  div;
    logic [9:0]  h_cnt, v_cnt;
    logic [15:0] acc, acc_sum;
    logic        first_line, frame_bad;
    logic        hs_fall, vs_fall, tick, capture;
    logic        line_err, frame_err;
    logic [10:0] line_len, frame_len;
    logic [8:0]  err_nx;

    always_ff @(posedge clk_100m) begin
        if (rst) begin
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            hs_prev <= 1'b1;
            vs_prev <= 1'b1;
            rgb_q   <= 8'h00;
        end else begin
            hs_q    <= vga_hsync;
            vs_q    <= vga_vsync;
            hs_prev <= hs_q;
            vs_prev <= vs_q;
            rgb_q   <= {vga_r, vga_g, vga_b};
        end
    end

    // The hsync-fall cycle itself is tick 0; the divider then counts 1,2,3,0.
    assign hs_fall   = hs_prev & ~hs_q;
    assign vs_fall   = vs_prev & ~vs_q;
    assign tick      = hs_fall | (div == 2'd0);
    assign line_len  = {1'b0, h_cnt} + 11'd1;
    assign frame_len = {1'b0, v_cnt} + 11'd1;

    assign line_err  = hs_fall && (line_len != H_TOTAL_L) &&
                       ((state == LOCKED) || (state == ALIGN && !first_line));
    assign frame_err = vs_fall && (frame_len != V_TOTAL_L) && (state != SEARCH);

    assign capture = (state == LOCKED) && tick &&
                     (h_cnt >= H_LO) && (h_cnt < H_HI) &&
                     (v_cnt >= V_LO) && (v_cnt < V_HI);

    assign acc_sum = acc + (pix_valid ? {8'h00, pix_rgb} : 16'h0000);
    assign err_nx  = {1'b0, err_count} + 9'(line_err) + 9'(frame_err);

    always_ff @(posedge clk_100m) begin
        if (rst) begin
            div   <= 2'd0;
            h_cnt <= 10'd0;
            v_cnt <= 10'd0;
        end else begin
            div <= hs_fall ? 2'd1 : div + 2'd1;
            if (hs_fall)
                h_cnt <= 10'd0;
            else if (tick && h_cnt != 10'h3FF)
                h_cnt <= h_cnt + 10'd1;
            // vsync fall wins over a coincident hsync fall
            if (vs_fall)
                v_cnt <= 10'd0;
            else if (hs_fall && v_cnt != 10'h3FF)
                v_cnt <= v_cnt + 10'd1;
        end
    end

    always_ff @(posedge clk_100m) begin
        if (rst) state <= SEARCH;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            SEARCH: if (vs_fall) state_nx = ALIGN;
            ALIGN:  if (vs_fall && !frame_bad && !line_err && !frame_err) state_nx = LOCKED;
            LOCKED: if (line_err || frame_err) state_nx = SEARCH;
            default: state_nx = SEARCH;
        endcase
    end

    always_comb begin
        locked = (state == LOCKED);
    end

    // The line closing the SEARCH->ALIGN transition may be a partial one, so skip it.
    always_ff @(posedge clk_100m) begin
        if (rst) begin
            first_line <= 1'b0;
            frame_bad  <= 1'b0;
        end else begin
            if (state == SEARCH && state_nx == ALIGN)
                first_line <= 1'b1;
            else if (state == ALIGN && hs_fall)
                first_line <= 1'b0;
            if (vs_fall)
                frame_bad <= 1'b0;
            else if (state == ALIGN && line_err)
                frame_bad <= 1'b1;
        end
    end

    always_ff @(posedge clk_100m) begin
        if (rst) begin
            pix_valid <= 1'b0;
            pix_x     <= 10'd0;
            pix_y     <= 9'd0;
            pix_rgb   <= 8'h00;
        end else begin
            pix_valid <= capture;
            if (capture) begin
                pix_x   <= h_cnt - H_LO;
                pix_y   <= 9'(v_cnt - V_LO);
                pix_rgb <= rgb_q;
            end
        end
    end

    always_ff @(posedge clk_100m) begin
        if (rst) begin
            acc        <= 16'h0000;
            frame_sum  <= 16'h0000;
            frame_done <= 1'b0;
            err_count  <= 8'h00;
        end else begin
            frame_done <= vs_fall && (state == LOCKED) && !frame_err;
            if (vs_fall) begin
                acc <= 16'h0000;
                if (state == LOCKED && !frame_err)
                    frame_sum <= acc_sum;
            end else begin
                acc <= acc_sum;
            end
            err_count <= err_nx[8] ? 8'hFF : err_nx[7:0];
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on a shrunken raster (20 ticks x 10 lines, 10x5 active).
`timescale 1ns/1ps
module tb_vga_capture;

    logic        clk_100m = 1'b0;
    logic        rst = 1'b1;
    logic        vga_hsync = 1'b1, vga_vsync = 1'b1;
    logic [2:0]  vga_r = 3'd0, vga_g = 3'd0;
    logic [1:0]  vga_b = 2'd0;
    logic        pix_valid, frame_done, locked;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic [7:0]  pix_rgb, err_count;
    logic [15:0] frame_sum;

    vga_capture #(
        .H_TOTAL(20), .H_ACT_START(4), .H_ACT(10),
        .V_TOTAL(10), .V_ACT_START(2), .V_ACT(5)
    ) dut (
        .clk_100m(clk_100m), .rst(rst),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
        .frame_done(frame_done), .frame_sum(frame_sum),
        .locked(locked), .err_count(err_count)
    );

    always #5 clk_100m = ~clk_100m;

    int cyc = 0;
    always @(posedge clk_100m) cyc <= cyc + 1;

    int n_cmp = 0, n_bad = 0;
    int n_strobe = 0, done_cnt = 0, hold_err = 0;
    int a5_cyc = -1, pin_cyc = 0;
    logic [15:0] mon_sum = 16'h0;
    logic [9:0]  last_x = 10'd0, a5_x = 10'h3FF;
    logic [8:0]  last_y = 9'd0, a5_y = 9'h1FF;
    logic [26:0] prev_out = 27'd0;
    logic        rst_d = 1'b1;

    always @(negedge clk_100m) begin
        if (!rst && pix_valid) begin
            n_strobe++;
            mon_sum = mon_sum + {8'h00, pix_rgb};
            last_x = pix_x;
            last_y = pix_y;
            if (pix_rgb == 8'hA5) begin
                a5_x = pix_x;
                a5_y = pix_y;
                a5_cyc = cyc;
            end
        end
        if (!rst && !rst_d && !pix_valid && ({pix_x, pix_y, pix_rgb} != prev_out))
            hold_err++;
        if (!rst && frame_done) done_cnt++;
        prev_out = {pix_x, pix_y, pix_rgb};
        rst_d = rst;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic h, input logic v, input logic [7:0] rgb);
        @(posedge clk_100m);
        #1;
        vga_hsync = h;
        vga_vsync = v;
        {vga_r, vga_g, vga_b} = rgb;
    endtask

    // hsync low for ticks 0-1 of each line, vsync low for lines 0-1; edges coincide at line 0.
    task automatic drive_line(input int l, input int ticks, input logic [7:0] rgb, input bit mark);
        logic [7:0] px;
        for (int t = 0; t < ticks; t++) begin
            for (int c = 0; c < 4; c++) begin
                px = (mark && l == 2 && t == 5) ? 8'hA5 : rgb;
                drive(t >= 2, l >= 2, px);
                if (mark && l == 2 && t == 5 && c == 0) pin_cyc = cyc;
            end
        end
    endtask

    task automatic drive_frame(input int from, input int nlines, input int short_l,
                               input logic [7:0] rgb, input bit mark);
        for (int l = from; l < nlines; l++)
            drive_line(l, (l == short_l) ? 19 : 20, rgb, mark);
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_pix_valid"},  32'(pix_valid),  32'd0);
        chk({pfx, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({pfx, "_locked"},     32'(locked),     32'd0);
        chk({pfx, "_pix_x"},      32'(pix_x),      32'd0);
        chk({pfx, "_pix_y"},      32'(pix_y),      32'd0);
        chk({pfx, "_pix_rgb"},    32'(pix_rgb),    32'd0);
        chk({pfx, "_frame_sum"},  32'(frame_sum),  32'd0);
        chk({pfx, "_err_count"},  32'(err_count),  32'd0);
    endtask

    int          n0;
    logic [15:0] s0;

    initial begin
        repeat (3) @(posedge clk_100m);
        @(negedge clk_100m);
        chk_reset_outputs("rst");
        @(posedge clk_100m);
        #1 rst = 1'b0;

        // A: first vsync fall, SEARCH -> ALIGN
        drive_frame(0, 10, -1, 8'hFF, 1'b0);
        chk("a_locked", 32'(locked), 32'd0);

        // B: second vsync fall locks; captured with one A5 pixel at (0,0)
        n0 = n_strobe; s0 = mon_sum;
        drive_frame(0, 10, -1, 8'hFF, 1'b1);
        chk("b_locked", 32'(locked), 32'd1);
        chk("b_strobes", n_strobe - n0, 32'd50);
        chk("b_sum", {16'h0, mon_sum - s0}, 32'h3174);
        chk("b_a5_x", 32'(a5_x), 32'd0);
        chk("b_a5_y", 32'(a5_y), 32'd0);
        chk("b_latency", a5_cyc - pin_cyc, 32'd2);
        chk("b_last_xy", {13'h0, last_x, last_y}, {13'h0, 10'd9, 9'd4});

        // C: frame_done reports B
        n0 = n_strobe; s0 = mon_sum;
        drive_frame(0, 10, -1, 8'h3C, 1'b0);
        chk("c_done_cnt", done_cnt, 32'd1);
        chk("c_frame_sum", 32'(frame_sum), 32'h3174);
        chk("c_strobes", n_strobe - n0, 32'd50);
        chk("c_sum", {16'h0, mon_sum - s0}, 32'h0BB8);

        // D: line 4 is 19 ticks -> line error, lock lost after 3 captured rows
        n0 = n_strobe;
        drive_frame(0, 10, 4, 8'h55, 1'b0);
        chk("d_done_cnt", done_cnt, 32'd2);
        chk("d_frame_sum", 32'(frame_sum), 32'h0BB8);
        chk("d_err_count", 32'(err_count), 32'd1);
        chk("d_locked", 32'(locked), 32'd0);
        chk("d_strobes", n_strobe - n0, 32'd30);

        // E: realign, nothing captured
        n0 = n_strobe;
        drive_frame(0, 10, -1, 8'h11, 1'b0);
        chk("e_strobes", n_strobe - n0, 32'd0);
        chk("e_locked", 32'(locked), 32'd0);
        chk("e_done_cnt", done_cnt, 32'd2);

        // F: relocked, captured
        n0 = n_strobe;
        drive_frame(0, 10, -1, 8'h22, 1'b0);
        chk("f_locked", 32'(locked), 32'd1);
        chk("f_strobes", n_strobe - n0, 32'd50);

        // G: only 9 lines; its start reports F
        drive_frame(0, 9, -1, 8'h33, 1'b0);
        chk("g_done_cnt", done_cnt, 32'd3);
        chk("g_frame_sum", 32'(frame_sum), 32'h06A4);
        chk("g_err_count", 32'(err_count), 32'd1);
        chk("g_locked", 32'(locked), 32'd1);

        // H: the short frame G is rejected at this vsync fall
        drive_line(0, 20, 8'h44, 1'b0);
        chk("h_locked", 32'(locked), 32'd0);
        chk("h_err_count", 32'(err_count), 32'd2);
        chk("h_frame_sum", 32'(frame_sum), 32'h06A4);
        chk("h_done_cnt", done_cnt, 32'd3);
        chk("h_v_cnt_zero", 32'(dut.v_cnt), 32'd0);
        drive_frame(1, 10, -1, 8'h44, 1'b0);

        // I: align; J: lock, then reset mid-frame
        drive_frame(0, 10, -1, 8'h66, 1'b0);
        chk("i_locked", 32'(locked), 32'd0);
        drive_frame(0, 5, -1, 8'h66, 1'b0);
        chk("j_locked", 32'(locked), 32'd1);
        @(posedge clk_100m);
        #1 rst = 1'b1;
        @(posedge clk_100m);
        @(negedge clk_100m);
        chk_reset_outputs("mid_rst");
        @(posedge clk_100m);
        #1 rst = 1'b0;
        drive_frame(5, 10, -1, 8'h66, 1'b0);

        // K: first vsync fall after reset only aligns; L: second one locks
        drive_line(0, 20, 8'h77, 1'b0);
        chk("k_locked", 32'(locked), 32'd0);
        drive_frame(1, 10, -1, 8'h77, 1'b0);
        drive_line(0, 20, 8'h88, 1'b0);
        chk("l_locked", 32'(locked), 32'd1);
        chk("l_err_count", 32'(err_count), 32'd0);
        chk("hold_stable", hold_err, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
